// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with an 8-entry first-word-fall-through receive FIFO.
// Deserialises frames on rx at baud_rate clocks per bit and buffers the bytes.
// Framing errors and breaks are reported as single-cycle pulses; a byte
// dropped on a full FIFO sets a sticky overrun flag.
module uart_rx_fifo #(
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_40,
  input  logic               reset,
  input  logic               rx,
  input  logic [15:0]        baud_rate,
  output logic [7:0]         rx_data,
  output logic               rx_data_valid,
  input  logic               rx_read_strobe,
  output logic [FIFO_AW:0]   rx_count,
  output logic               framing_error,
  output logic               break_detect,
  output logic               overrun,
  input  logic               clear_errors
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d;
  logic [15:0]            baud_eff, b_q, cnt_q, half_m1, b_m1;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic                   start_edge, push_req, fe_d, be_d;

  logic [7:0]             mem [DEPTH];
  logic [FIFO_AW-1:0]     wptr_q, rptr_q;
  logic                   full, do_pop, do_push;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign baud_eff = (baud_rate < 16'd4) ? 16'd4 : baud_rate;
  assign half_m1  = (b_q >> 1) - 16'd1;
  assign b_m1     = b_q - 16'd1;

  // Synchroniser chain on rx plus a one-cycle delayed copy for edge detection.
  always_ff @(posedge CLK_40) begin
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    if (reset) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_d  <= rxs;
    end
  end

  // Next-state and sample-point decode for the receive FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    start_edge = 1'b0;
    push_req   = 1'b0;
    fe_d       = 1'b0;
    be_d       = 1'b0;
    case (state_q)
      IDLE: if (rxs_d && !rxs) begin
        state_d    = START;
        start_edge = 1'b1;
      end
      START: if (cnt_q == half_m1) state_d = rxs ? IDLE : DATA;
      DATA:  if (cnt_q == b_m1 && idx_q == 3'd7) state_d = STOP;
      STOP: if (cnt_q == b_m1) begin
        if (rxs) begin
          push_req = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_HIGH;
          if (shift_q == 8'h00) be_d = 1'b1;
          else                  fe_d = 1'b1;
        end
      end
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, bit timing counter, shift register and error pulses.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      b_q           <= 16'd4;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      state_q       <= state_d;
      framing_error <= fe_d;
      break_detect  <= be_d;
      case (state_q)
        IDLE: begin
          // The edge-detection cycle is cycle 0 of the start bit.
          cnt_q <= start_edge ? 16'd1 : 16'd0;
          idx_q <= '0;
          if (start_edge) b_q <= baud_eff;
        end
        START: cnt_q <= (cnt_q == half_m1) ? 16'd0 : cnt_q + 16'd1;
        DATA: begin
          if (cnt_q == b_m1) begin
            cnt_q           <= '0;
            shift_q[idx_q]  <= rxs;
            idx_q           <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP:    cnt_q <= (cnt_q == b_m1) ? 16'd0 : cnt_q + 16'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign full          = (rx_count == CNT_FULL);
  assign rx_data_valid = (rx_count != '0);
  assign do_pop        = rx_read_strobe && rx_data_valid;
  assign do_push       = push_req && (!full || do_pop);
  assign rx_data       = rx_data_valid ? mem[rptr_q] : 8'h00;

  // FIFO storage written at the write pointer.
  always_ff @(posedge CLK_40) begin
    // NOTE: storage is not reset; the count and the output mux keep stale entries invisible.
    if (do_push) mem[wptr_q] <= shift_q;
  end

  // FIFO pointers, occupancy count and sticky overrun flag.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rx_count <= '0;
      overrun  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
      if (push_req && full && !do_pop) overrun <= 1'b1;
      else if (clear_errors)           overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with a byte scoreboard queue.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_rate = 16'd8;
  logic        rx_read_strobe = 1'b0;
  logic        clear_errors = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [3:0]  rx_count;
  logic        framing_error, break_detect, overrun;

  int n_checks = 0;
  int n_fails  = 0;
  int fe_cnt   = 0;
  int be_cnt   = 0;
  int fe0, be0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.FIFO_AW(3), .SYNC_STAGES(2)) dut (
    .CLK_40         (clk),
    .reset          (reset),
    .rx             (rx),
    .baud_rate      (baud_rate),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_read_strobe (rx_read_strobe),
    .rx_count       (rx_count),
    .framing_error  (framing_error),
    .break_detect   (break_detect),
    .overrun        (overrun),
    .clear_errors   (clear_errors)
  );

  always #5 clk = ~clk;

  // Count error pulses as they occur.
  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (break_detect)  be_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, b cycles each.
  // Returns b-1 cycles into the stop bit, leaving rx at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int b);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 rx = f[i];
      repeat (b - 1) @(posedge clk);
    end
  endtask

  task automatic send_good(input logic [7:0] d, input int b);
    if (exp_q.size() < 8) exp_q.push_back(d);
    send_frame(d, 1'b1, b);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    @(negedge clk);
    check({tag, "_valid"}, 32'(rx_data_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(e));
    @(posedge clk);
    #1 rx_read_strobe = 1'b1;
    @(posedge clk);
    #1 rx_read_strobe = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data",    32'(rx_data),       32'd0);
    check("rst_valid",   32'(rx_data_valid), 32'd0);
    check("rst_count",   32'(rx_count),      32'd0);
    check("rst_fe",      32'(framing_error), 32'd0);
    check("rst_break",   32'(break_detect),  32'd0);
    check("rst_overrun", 32'(overrun),       32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(5);

    // 1: single byte then pop
    send_good(8'hC1, 8);
    idle(4);
    @(negedge clk);
    check("t1_count", 32'(rx_count), 32'd1);
    check("t1_fe",    32'(fe_cnt),   32'd0);
    check("t1_break", 32'(be_cnt),   32'd0);
    check("t1_ovr",   32'(overrun),  32'd0);
    read_check("t1");
    idle(2);
    @(negedge clk);
    check("t1_count_after", 32'(rx_count),      32'd0);
    check("t1_valid_after", 32'(rx_data_valid), 32'd0);

    // 2: start-bit glitch rejected, next frame received
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    idle(20);
    @(negedge clk);
    check("t2_count", 32'(rx_count), 32'd0);
    check("t2_fe",    32'(fe_cnt),   32'd0);
    check("t2_break", 32'(be_cnt),   32'd0);
    idle(1);
    send_good(8'h55, 8);
    idle(4);
    read_check("t2");

    // 3: framing error, line held low, recovery
    idle(4);
    fe0 = fe_cnt;
    be0 = be_cnt;
    send_frame(8'h55, 1'b0, 8);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t3_fe",    32'(fe_cnt),   32'(fe0 + 1));
    check("t3_break", 32'(be_cnt),   32'(be0));
    check("t3_count", 32'(rx_count), 32'd0);
    @(posedge clk);
    #1 rx = 1'b1;
    idle(10);
    send_good(8'hA3, 8);
    idle(4);
    @(negedge clk);
    check("t3_fe_once", 32'(fe_cnt), 32'(fe0 + 1));
    read_check("t3");

    // 4: break
    idle(4);
    fe0 = fe_cnt;
    be0 = be_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (160) @(posedge clk);
    #1 rx = 1'b1;
    idle(10);
    @(negedge clk);
    check("t4_break", 32'(be_cnt),   32'(be0 + 1));
    check("t4_fe",    32'(fe_cnt),   32'(fe0));
    check("t4_count", 32'(rx_count), 32'd0);
    idle(4);

    // 5: overrun on the ninth byte
    for (int i = 1; i <= 9; i++) send_good(8'(i), 8);
    idle(4);
    @(negedge clk);
    check("t5_count", 32'(rx_count), 32'd8);
    check("t5_ovr",   32'(overrun),  32'd1);
    for (int i = 0; i < 8; i++) read_check("t5");
    idle(2);
    @(negedge clk);
    check("t5_empty",      32'(rx_count), 32'd0);
    check("t5_ovr_sticky", 32'(overrun),  32'd1);
    @(posedge clk);
    #1 clear_errors = 1'b1;
    @(posedge clk);
    #1 clear_errors = 1'b0;
    @(negedge clk);
    check("t5_ovr_clear", 32'(overrun), 32'd0);

    // Clamp: baud_rate below 4 runs at 4 cycles per bit
    idle(2);
    baud_rate = 16'd2;
    send_good(8'h96, 4);
    idle(4);
    read_check("clamp");
    idle(4);

    // 6: reset in the middle of a 347-cycle frame
    baud_rate = 16'd347;
    fe0 = fe_cnt;
    be0 = be_cnt;
    begin
      logic [9:0] f;
      f = {1'b1, 8'h3C, 1'b0};
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1 rx = f[i];
        repeat (346) @(posedge clk);
      end
      @(posedge clk);
      #1 rx = f[5];
      repeat (173) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rx = 1'b1;
    end
    idle(12 * 347);
    @(negedge clk);
    check("t6_rst_count", 32'(rx_count),      32'd0);
    check("t6_rst_valid", 32'(rx_data_valid), 32'd0);
    check("t6_rst_flags", 32'(fe_cnt + be_cnt), 32'(fe0 + be0));
    idle(1);
    send_good(8'h7E, 347);
    idle(4);
    read_check("t6");

    // 6: full FIFO, pop and push in the same cycle
    idle(4);
    baud_rate = 16'd8;
    for (int i = 0; i < 8; i++) send_good(8'h10 + 8'(i), 8);
    idle(4);
    @(negedge clk);
    check("t6_full",      32'(rx_count), 32'd8);
    check("t6_full_ovr",  32'(overrun),  32'd0);
    check("t6_head",      32'(rx_data),  32'(exp_q[0]));
    void'(exp_q.pop_front());
    exp_q.push_back(8'h5A);
    idle(1);
    fork
      send_frame(8'h5A, 1'b1, 8);
      begin
        repeat ((8 >> 1) + 9 * 8 + 2) @(posedge clk);
        #1 rx_read_strobe = 1'b1;
        @(posedge clk);
        #1 rx_read_strobe = 1'b0;
      end
    join
    idle(4);
    @(negedge clk);
    check("t6_pp_count", 32'(rx_count), 32'd8);
    check("t6_pp_ovr",   32'(overrun),  32'd0);
    for (int i = 0; i < 8; i++) read_check("t6_drain");
    idle(2);
    @(negedge clk);
    check("t6_drained", 32'(rx_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Standalone UART receiver for the host link. It deserialises 8N1 frames on `rx` at the rate set by `baud_rate`, using the same clocks-per-bit convention as the existing uart transmitter. Received bytes are buffered in a small first-word-fall-through FIFO so a slower consumer (command parser) can drain them. Framing, break and overrun conditions are reported to the consumer.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth = 8).
SYNC_STAGES, 2, flip-flop synchroniser stages on `rx` (minimum 2).

Ports:
CLK_40  input  1  system clock, 40 MHz.
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial input; idles high.
baud_rate  input  16  CLK_40 cycles per bit (40000000/115200 = 347); values below 4 are treated as 4.
rx_data  output  8  FIFO head byte; valid only while `rx_data_valid` = 1.
rx_data_valid  output  1  FIFO not empty.
rx_read_strobe  input  1  pops the head byte when high with `rx_data_valid` = 1.
rx_count  output  FIFO_AW+1  bytes held, 0..8.
framing_error  output  1  one-cycle pulse: stop bit sampled low on a non-break frame.
break_detect  output  1  one-cycle pulse: data bits and stop bit all sampled low.
overrun  output  1  sticky flag: a good byte was dropped because the FIFO was full.
clear_errors  input  1  clears `overrun`.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops 1. Reset mid-frame abandons the frame and nothing is pushed.
- `rx` passes through the SYNC_STAGES synchroniser. `rxs` below means the synchroniser output; `rxs_d` is its value one cycle earlier.
- `baud_rate` (after clamping) is latched as B on start-edge detection. Changes during a frame take effect at the next frame.
- Bit counter: 16-bit, counts 0..B-1.
- FSM states:
  - IDLE: `rxs_d` = 1 and `rxs` = 0 → START, counter cleared.
  - START: when counter = (B>>1) - 1, sample `rxs`. If 0 → DATA with counter cleared and bit index 0. If 1 (glitch) → IDLE, no flags.
  - DATA: when counter = B-1, sample `rxs` into shift register bit [index], LSB first. Clear counter. After index 7 → STOP.
  - STOP: when counter = B-1, sample `rxs`.
    - 1 → push byte and go to IDLE.
    - 0 with data ≠ 0 → pulse `framing_error`, discard byte, go to WAIT_HIGH.
    - 0 with data = 0 → pulse `break_detect`, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then → IDLE. No new frame is recognised while `rx` is held low.
- Sampling points: every sample falls at mid-bit. The stop sample lands (B>>1) + 9·B - 1 cycles after the start-edge detection cycle.
- Push timing: the byte is pushed in the stop-sample cycle. `rx_data_valid` rises and `rx_data`/`rx_count` update on the following cycle.
- FIFO: 8 entries, binary read and write pointers with wrap-around at depth, plus a separate count.
  - Pop when empty: ignored.
  - Push when full with no simultaneous pop: byte dropped; `overrun` is set on the next cycle.
  - Push and pop in the same cycle: both take effect and `rx_count` is unchanged. This includes the full case, where the byte is accepted and no overrun occurs. It also includes the empty case, where the pop is ignored and only the push takes effect.
- `overrun` stays set until `clear_errors` or reset. If `clear_errors` and a new overrun occur in the same cycle, set wins.
- `framing_error` and `break_detect` never assert together. They are never asserted in the same cycle as a push.

Test Plan:
1. baud_rate=8; drive frame 0xC1 (start, LSB first, stop) at 8 cycles/bit → one byte 0xC1. `rx_data_valid`=1, `rx_count`=1, no flags. Then pulse `rx_read_strobe` for 1 cycle → `rx_count`=0, `rx_data_valid`=0.
2. baud_rate=8; drive `rx` low for 2 cycles, then high → FSM returns to IDLE. No byte and no flags. A following 0x55 frame is received correctly.
3. baud_rate=8; drive 0x55 with stop bit low → exactly one `framing_error` pulse and `rx_count` stays 0. Holding `rx` low for 40 more cycles produces no further frame. After `rx` goes high, a 0xA3 frame is received.
4. baud_rate=8; hold `rx` low for 20 bit times → one `break_detect` pulse, no push, and no `framing_error`.
5. baud_rate=8; send bytes 0x01..0x09 back-to-back without reading → `rx_count`=8 and `overrun`=1. Reads return 0x01..0x08 in order. `clear_errors` clears `overrun`.
6. baud_rate=347; send 0x3C and assert `reset` for 1 cycle at data bit 4 → nothing is pushed. A subsequent 0x7E frame is received correctly. Also hold the FIFO full, then pop and receive in the same cycle → `rx_count` stays 8 and `overrun` stays 0.
